outgoing_response_buffer: RTL
=============================

# outgoing_response_buffer

Buffers AXI R-channel beats returned by the ordering unit and presents them in arrival order to the AXI master. It is the response-side counterpart of the AR request buffer. It supports two release policies:
- cut-through: forward each beat as soon as it is stored;
- store-and-forward: hold beats until a complete burst (beat with last=1) is buffered, so the master sees gap-free bursts.

## Interface
Parameters:
- ID_WIDTH, 8, R ID width
- DATA_WIDTH, 64, R data width
- RESP_WIDTH, 2, R resp width
- DEPTH, 16, beats stored; must be ≥ 2
- STORE_FWD, 1, 1 = store-and-forward, 0 = cut-through

Ports (CNT_W = $clog2(DEPTH+1)):
- clk  input  1  single clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- r_in  r_if.receiver  —  beats from the ordering unit (valid, ready, id, data, resp, last)
- r_out  r_if.sender  —  beats to the AXI master (same fields)
- occupancy  output  CNT_W  registered count of stored beats
- bursts_pending  output  CNT_W  registered count of stored beats with last=1

## Operation
- Storage:
  - circular array of DEPTH entries {id, data, resp, last};
  - wr_ptr and rd_ptr each wrap from DEPTH-1 to 0;
  - count of 0..DEPTH.
- Flags:
  - empty = (count == 0);
  - full = (count == DEPTH).
- Push and pop:
  - r_in.ready = ~full;
  - push = r_in.valid & r_in.ready;
  - pop = r_out.valid & r_out.ready.
- On push: write the entry at wr_ptr, then advance wr_ptr.
- On pop: advance rd_ptr.
- Count update:
  - +1 on push only;
  - −1 on pop only;
  - unchanged when both occur or neither occurs.
- bursts_pending update:
  - +1 on push with r_in.last=1;
  - −1 on pop with the head entry's last=1;
  - unchanged when both occur.
- Head fields:
  - r_out.{id, data, resp, last} = mem[rd_ptr] when not empty;
  - all zeros when empty.
- Release policy (r_out.valid):
  - STORE_FWD=0: r_out.valid = ~empty.
  - STORE_FWD=1: r_out.valid = ~empty & ((bursts_pending != 0) | full).
  - The full term is a deadlock escape for bursts longer than DEPTH: once full, beats drain cut-through until a last beat is popped or the buffer is no longer full.
- Once r_out.valid is asserted, it must stay asserted with the head fields stable until pop. This holds by construction: a push can only increase bursts_pending, and the full term drops only after a pop.
- Beat order is strict FIFO. The block performs no ID reordering and no field modification.
- Reset (asynchronous assert):
  - wr_ptr, rd_ptr, count and bursts_pending go to 0;
  - r_out.valid = 0, r_out fields = 0, r_in.ready = 1;
  - occupancy = 0, bursts_pending = 0;
  - storage contents are not reset.
- Reset asserted mid-burst discards all buffered beats, including partial bursts. No beat may appear on r_out after reset until a new push.

## Timing
- Push-to-output latency:
  - STORE_FWD=0: a beat pushed in cycle N is visible on r_out with valid=1 in cycle N+1.
  - STORE_FWD=1: r_out.valid rises in the cycle after the last beat of the first complete burst is pushed.
- No combinational path from r_in to r_out. No combinational path from r_out.ready to r_in.ready.
- r_in.ready depends only on registered count:
  - when full, ready=0 even if a pop occurs in the same cycle;
  - ready returns to 1 the cycle after the pop.
- Push and pop in the same cycle when neither empty nor full: both complete and count is unchanged.
- Push into an empty buffer is never popped in the same cycle; the bypass path is not present.
- Back-to-back throughput is one beat per cycle in both directions when not full/empty. In STORE_FWD=1 this applies once a burst is complete.
- Pointer wrap: after DEPTH pushes, wr_ptr returns to 0 with no lost or duplicated beat.

## Test plan
- Reset, then STORE_FWD=0, one beat {id=0x3, data=0xA5, resp=0, last=1}:
  - r_out.valid=1 one cycle after the push, with identical fields;
  - after pop, occupancy=0 and valid=0.
- STORE_FWD=1, 4-beat burst id=0x7 (data 1..4, last on beat 4), r_out.ready=1 throughout:
  - valid stays 0 during beats 1–3;
  - valid rises the cycle after beat 4;
  - beats 1..4 are then delivered on 4 consecutive cycles;
  - bursts_pending goes 1→0 on the last pop.
- DEPTH=16, r_out.ready=0, 20 single-beat pushes attempted:
  - 16 accepted, r_in.ready=0 from the cycle after the 16th;
  - then ready=1, 16 pops return data 0..15 in order;
  - 16 further push/pop pairs exercise pointer wrap with correct order.
- STORE_FWD=1, 20-beat burst, master ready=1:
  - after 16 beats, full forces valid=1;
  - all 20 beats are delivered in order with no deadlock;
  - bursts_pending=0 at the end.
- Half-full buffer, push and pop asserted in the same cycle for 10 cycles:
  - occupancy constant;
  - output sequence matches input sequence offset by the stored depth.
- Reset asserted while 3 beats of an incomplete burst are stored:
  - outputs return to reset values immediately;
  - next valid appears only after a fresh push, and carries the fresh beat's data.

Source files
------------

// File: rtl/outgoing_response_buffer.sv
// Outgoing R-channel response buffer.
// Stores R beats from the ordering unit in a circular FIFO and presents them
// in arrival order to the AXI master, either cut-through or store-and-forward.
// Head fields are driven from stored state only, so there is no combinational
// path from the r_in side or from r_out_ready into the outputs.
module outgoing_response_buffer #(
    parameter int ID_WIDTH   = 8,
    parameter int DATA_WIDTH = 64,
    parameter int RESP_WIDTH = 2,
    parameter int DEPTH      = 16,
    parameter int STORE_FWD  = 1,
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    // beats from the ordering unit
    input  logic                  r_in_valid,
    output logic                  r_in_ready,
    input  logic [ID_WIDTH-1:0]   r_in_id,
    input  logic [DATA_WIDTH-1:0] r_in_data,
    input  logic [RESP_WIDTH-1:0] r_in_resp,
    input  logic                  r_in_last,
    // beats to the AXI master
    output logic                  r_out_valid,
    input  logic                  r_out_ready,
    output logic [ID_WIDTH-1:0]   r_out_id,
    output logic [DATA_WIDTH-1:0] r_out_data,
    output logic [RESP_WIDTH-1:0] r_out_resp,
    output logic                  r_out_last,
    // status
    output logic [CNT_W-1:0]      occupancy,
    output logic [CNT_W-1:0]      bursts_pending
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = ID_WIDTH + DATA_WIDTH + RESP_WIDTH + 1;

    logic [ENTRY_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] bursts_q, bursts_d;

    logic               empty_s;
    logic               full_s;
    logic               push_s;
    logic               pop_s;
    logic               valid_s;
    logic [ENTRY_W-1:0] head_s;

    assign empty_s = (count_q == CNT_W'(0));
    assign full_s  = (count_q == CNT_W'(DEPTH));

    // Ready depends only on the registered count; a pop while full does not reopen it this cycle.
    assign r_in_ready = ~full_s;
    assign push_s     = r_in_valid & ~full_s;
    assign pop_s      = valid_s & r_out_ready;

    // Head entry, forced to zero while empty so stale storage never leaks out.
    always_comb begin
        head_s = '0;
        if (!empty_s) begin
            head_s = mem_q[rd_ptr_q];
        end else begin
            head_s = '0;
        end
    end

    // Release policy; the full term lets bursts longer than the buffer drain instead of deadlocking.
    always_comb begin
        valid_s = 1'b0;
        if (STORE_FWD != 0) begin
            valid_s = ~empty_s & ((bursts_q != CNT_W'(0)) | full_s);
        end else begin
            valid_s = ~empty_s;
        end
    end

    assign r_out_valid = valid_s;
    assign {r_out_id, r_out_data, r_out_resp, r_out_last} = head_s;
    assign occupancy      = count_q;
    assign bursts_pending = bursts_q;

    // Next-state for pointers, beat count and complete-burst count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        bursts_d = bursts_q;

        if (push_s) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        case ({push_s & r_in_last, pop_s & head_s[0]})
            2'b10:   bursts_d = bursts_q + CNT_W'(1);
            2'b01:   bursts_d = bursts_q - CNT_W'(1);
            default: bursts_d = bursts_q;
        endcase
    end

    // Control state; reset discards everything buffered, including partial bursts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            bursts_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            bursts_q <= bursts_d;
        end
    end

    // Beat storage, deliberately not reset; the empty mask hides stale entries.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {r_in_id, r_in_data, r_in_resp, r_in_last};
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

endmodule
